// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional macro MULDIV_EARLY_OUT_EN: multiplies stop once the remaining multiplier is zero.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PREP = 3'd1;
   localparam logic [2:0] S_CALC = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]         state;
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   a_r, b_r;
   logic [2*WIDTH-1:0] acc;     // product, or {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] mcand;   // shifted multiplicand, or divisor in low half
   logic [WIDTH-1:0]   mplr;
   logic [CW-1:0]      cnt;
   logic               neg_q, neg_r, dz;

   logic               is_div, sgn, last;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] acc_mul, prod_f;
   logic [WIDTH:0]     div_top, div_diff;
   logic [WIDTH-1:0]   quo_f, rem_f, hi_f, lo_f;

   assign busy = (state == S_PREP) || (state == S_CALC) || (state == S_FIX);
   assign done = (state == S_DONE);

   always_comb begin
      is_div   = op_r[1];
      sgn      = ~op_r[0];
      abs_a    = (sgn && a_r[WIDTH-1]) ? ('0 - a_r) : a_r;
      abs_b    = (sgn && b_r[WIDTH-1]) ? ('0 - b_r) : b_r;
      acc_mul  = mplr[0] ? (acc + mcand) : acc;
      // restoring step: shifted partial remainder (with next dividend bit) minus divisor
      div_top  = acc[2*WIDTH-1:WIDTH-1];
      div_diff = div_top - {1'b0, mcand[WIDTH-1:0]};
`ifdef MULDIV_EARLY_OUT_EN
      last     = (cnt == CW'(WIDTH-1)) || (!is_div && (mplr[WIDTH-1:1] == '0));
`else
      last     = (cnt == CW'(WIDTH-1));
`endif
      prod_f   = neg_q ? ('0 - acc) : acc;
      quo_f    = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      rem_f    = neg_r ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
      if (is_div) begin
         hi_f = rem_f;
         lo_f = dz ? '1 : quo_f;
      end else begin
         hi_f = prod_f[2*WIDTH-1:WIDTH];
         lo_f = prod_f[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         op_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplr     <= '0;
         cnt      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz       <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else begin
         if (!busy) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= S_PREP;
                  op_r     <= op;
                  a_r      <= a;
                  b_r      <= b;
                  div_zero <= 1'b0;
               end else begin
                  state    <= S_IDLE;
               end
            end
            S_PREP: begin
               acc   <= is_div ? {{WIDTH{1'b0}}, abs_a} : '0;
               mcand <= is_div ? {{WIDTH{1'b0}}, abs_b} : {{WIDTH{1'b0}}, abs_a};
               mplr  <= abs_b;
               neg_q <= sgn && (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
               neg_r <= sgn && a_r[WIDTH-1];
               dz    <= is_div && (b_r == '0);
               cnt   <= '0;
               state <= S_CALC;
            end
            S_CALC: begin
               if (is_div) begin
                  acc <= div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                         : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               end else begin
                  acc   <= acc_mul;
                  mcand <= {mcand[2*WIDTH-2:0], 1'b0};
                  mplr  <= {1'b0, mplr[WIDTH-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (last) state <= S_FIX;
            end
            S_FIX: begin
               hi       <= hi_f;
               lo       <= lo_f;
               div_zero <= is_div && dz;
               state    <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
